i2c_mt9v034_cfg_master: RTL and testbench
=========================================

// Module: i2c_mt9v034_cfg_master
// PURPOSE
//  I2C initiator that walks the MT9V034 config LUT and writes or reads each entry over SCCB/I2C.
//  Drives lut_index and consumes {reg_addr[7:0], data[16]} from the combinational config LUT.
//  Sits between the per-sensor LUT (L/R) and the sensor pins. Signals cfg_done to release
//  the capture path.
// PARAMETERS
//  CLK_DIV     62       clk cycles per SCL quarter-period (bit = 4*CLK_DIV; 50MHz -> ~200kHz)
//  INIT_DLY    1000000  clk cycles idle after reset before first transaction (sensor power-up)
//  SLAVE_ADDR  7'h48    7-bit sensor address (write byte 0x90, read byte 0x91)
//  READ_CNT    2        LUT indices 0..READ_CNT-1 are read transactions; the rest are writes
//  SKIP_DLY    1000     idle cycles for a hold-off slot (write index whose reg_addr==8'h00)
//  MAX_RETRY   3        re-attempts of one entry after NACK before it is abandoned
// PORTS
//  clk          in   1   system clock
//  rst          in   1   synchronous active-high reset
//  lut_index    out  8   LUT entry being executed
//  lut_data     in   24  {reg_addr, data_hi, data_lo} for lut_index (combinational)
//  lut_size     in   8   number of LUT entries; entries 0..lut_size-1 are executed
//  i2c_scl      out  1   SCL; board pull-up, driven push-pull
//  i2c_sda_oe   out  1   1 = pull SDA low; 0 = release SDA (open-drain, data always 0)
//  i2c_sda_i    in   1   sampled SDA level
//  rd_data      out  16  last read word, {hi, lo}
//  rd_valid     out  1   one-cycle pulse when rd_data updates
//  cfg_done     out  1   sticky; all entries processed
//  cfg_err      out  1   sticky; at least one entry abandoned after MAX_RETRY NACKs
// BEHAVIOUR
//  Reset: lut_index=0, i2c_scl=1, i2c_sda_oe=0, rd_data=0, rd_valid=0, cfg_done=0,
//   cfg_err=0; FSM->INIT. Reset mid-transaction releases the bus on the next cycle and
//   issues no STOP. After reset the whole sequence restarts from index 0 after INIT_DLY.
//  Timing: quarter-tick counter 0..CLK_DIV-1. SDA changes only in SCL-low quarter 1.
//   SDA is sampled in SCL-high quarter 2. START = SDA falls while SCL=1. STOP = SDA rises
//   while SCL=1.
//  FSM: INIT -> LOAD -> {SKIP | START} -> ADDR_W -> ACK -> REG -> ACK -> then:
//   write path: DHI -> ACK -> DLO -> ACK -> STOP -> NEXT.
//   read path (lut_index<READ_CNT): RESTART -> ADDR_R -> ACK -> RDHI -> MACK -> RDLO ->
//   MNACK -> STOP -> NEXT.
//  LOAD: lut_data is latched one cycle after lut_index settles. If lut_index>=READ_CNT
//   and reg_addr==8'h00, go to SKIP (SKIP_DLY idle cycles, no bus activity), then NEXT.
//  Bytes are sent MSB first, 8 bits, then a 9th ACK clock with SDA released. ACK=0.
//  NACK at any ACK state: STOP, increment retry count, restart the same entry. After
//   MAX_RETRY retries: set cfg_err, clear retry count, NEXT. Retry count clears on NEXT.
//  Read: master drives ACK (oe=1) after the hi byte and NACK (oe=0) after the lo byte.
//   rd_data and rd_valid update in the cycle STOP is entered.
//  NEXT: if lut_index==lut_size-1 (or lut_size==0), go to DONE. Otherwise increment
//   lut_index, go to LOAD.
//  DONE: cfg_done=1, SCL=1, SDA released, lut_index holds. Terminal until rst.
//  Write transaction = START + 4x9 bits + STOP. Read = START + 2x9 + Sr + 3x9 + STOP.
//  lut_index is 8 bits and never wraps: lut_size<=255 supported.
// TESTING (CLK_DIV=2, INIT_DLY=10, SKIP_DLY=8; bench has an ACKing MT9V034 model)
//  Reset -> scl=1, sda_oe=0, lut_index=0, cfg_done=0. No SCL edge for 10 cycles.
//  Entry {0C,0001} at index 2 -> bus bytes 90,0C,00,01 each ACKed, then STOP,
//   lut_index becomes 3.
//  Read index 1, model returns 0x1313 -> bytes 90,00, Sr, 91. Master ACKs hi, NACKs lo.
//   rd_data=0x1313 with a 1-cycle rd_valid.
//  Index 5 = {00,1313} -> no START for >=8 cycles, lut_index advances to 6.
//  Model NACKs addr 0x90 for index 21 permanently -> 4 attempts each ended by STOP.
//   Then cfg_err=1 and index 22 proceeds.
//  lut_size=24 -> after index 23 STOP, cfg_done=1 and bus idle. rst asserted mid-byte
//   -> sda_oe=0, scl=1 next cycle, sequence restarts at index 0.

Source files
------------

// File: rtl/i2c_mt9v034_cfg_master.sv
// I2C/SCCB initiator that walks the MT9V034 configuration LUT, writing or reading each entry.
// Bus timing is built from four CLK_DIV-cycle quarters per bit; all bus outputs are registered.
module i2c_mt9v034_cfg_master #(
    parameter int         CLK_DIV    = 62,
    parameter int         INIT_DLY   = 1000000,
    parameter logic [6:0] SLAVE_ADDR = 7'h48,
    parameter int         READ_CNT   = 2,
    parameter int         SKIP_DLY   = 1000,
    parameter int         MAX_RETRY  = 3
) (
    input  logic        clk,
    input  logic        rst,
    output logic [7:0]  lut_index,
    input  logic [23:0] lut_data,
    input  logic [7:0]  lut_size,
    output logic        i2c_scl,
    output logic        i2c_sda_oe,
    input  logic        i2c_sda_i,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    output logic        cfg_done,
    output logic        cfg_err
);
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int DLY_MAX = (INIT_DLY > SKIP_DLY) ? INIT_DLY : SKIP_DLY;
    localparam int DLY_W   = $clog2(DLY_MAX + 1);
    localparam int RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [7:0] READ_LIM = 8'(READ_CNT);

    typedef enum logic [4:0] {
        S_INIT, S_LOAD, S_SKIP, S_START, S_ADDR_W, S_REG, S_DHI, S_DLO, S_ACK,
        S_RESTART, S_ADDR_R, S_RDHI, S_MACK, S_RDLO, S_MNACK, S_STOP, S_NEXT, S_DONE
    } state_t;

    state_t             state_q, ret_q, tx_ret;
    logic [DIV_W-1:0]   div_q;
    logic [1:0]         ph_q;
    logic [2:0]         bit_q;
    logic [DLY_W-1:0]   dly_q;
    logic [7:0]         shreg_q, idx_q;
    logic [15:0]        rx_q, rd_data_q;
    logic [23:0]        data_q;
    logic [RTY_W-1:0]   retry_q;
    logic               sda_s_q, nack_q, scl_q, oe_q, rd_valid_q, done_q, err_q;
    logic               scl_d, oe_d, tick, sample, slot_end, is_read;

    assign tick     = (div_q == DIV_W'(CLK_DIV - 1));
    assign sample   = tick && (ph_q == 2'd2);
    assign slot_end = tick && (ph_q == 2'd3);
    assign is_read  = (idx_q < READ_LIM);

    // Quarters 0-1 hold SCL low, 2-3 hold it high; SDA may only move as quarter 1 begins,
    // except for the deliberate START/STOP edges in quarter 3.
    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no latch is inferred.
        scl_d  = 1'b1;
        oe_d   = 1'b0;
        tx_ret = S_RDHI;
        case (state_q)
            S_START:   oe_d = (ph_q == 2'd3);
            S_RESTART: begin scl_d = ph_q[1]; oe_d = (ph_q == 2'd3); end
            S_ADDR_W, S_REG, S_DHI, S_DLO, S_ADDR_R: begin
                scl_d = ph_q[1];
                oe_d  = (ph_q == 2'd0) ? oe_q : ~shreg_q[7];
            end
            S_ACK, S_RDHI, S_RDLO, S_MNACK: begin
                scl_d = ph_q[1];
                oe_d  = (ph_q == 2'd0) ? oe_q : 1'b0;
            end
            S_MACK: begin scl_d = ph_q[1]; oe_d = (ph_q == 2'd0) ? oe_q : 1'b1; end
            S_STOP: begin scl_d = ph_q[1]; oe_d = (ph_q == 2'd0) ? oe_q : (ph_q != 2'd3); end
            default: ;
        endcase
        case (state_q)
            S_ADDR_W: tx_ret = S_REG;
            S_REG:    tx_ret = is_read ? S_RESTART : S_DHI;
            S_DHI:    tx_ret = S_DLO;
            S_DLO:    tx_ret = S_STOP;
            default:  tx_ret = S_RDHI;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_INIT;   ret_q <= S_REG;      div_q <= '0;     ph_q <= '0;
            bit_q <= '0;         dly_q <= '0;         shreg_q <= '0;   rx_q <= '0;
            data_q <= '0;        retry_q <= '0;       sda_s_q <= 1'b1; nack_q <= 1'b0;
            idx_q <= '0;         scl_q <= 1'b1;       oe_q <= 1'b0;    rd_data_q <= '0;
            rd_valid_q <= 1'b0;  done_q <= 1'b0;      err_q <= 1'b0;
        end else begin
            scl_q      <= scl_d;
            oe_q       <= oe_d;
            rd_valid_q <= 1'b0;
            div_q      <= tick ? '0 : div_q + DIV_W'(1);
            if (tick) ph_q <= ph_q + 2'd1;
            if (sample && state_q == S_ACK) sda_s_q <= i2c_sda_i;
            if (sample && (state_q == S_RDHI || state_q == S_RDLO)) rx_q <= {rx_q[14:0], i2c_sda_i};

            case (state_q)
                S_INIT: begin
                    if (dly_q == DLY_W'(INIT_DLY - 1)) begin
                        dly_q   <= '0;
                        state_q <= (lut_size == 8'd0) ? S_DONE : S_LOAD;
                    end else dly_q <= dly_q + DLY_W'(1);
                end
                S_LOAD: begin
                    data_q <= lut_data;
                    div_q  <= '0;
                    ph_q   <= '0;
                    bit_q  <= '0;
                    nack_q <= 1'b0;
                    dly_q  <= '0;
                    state_q <= (!is_read && lut_data[23:16] == 8'h00) ? S_SKIP : S_START;
                end
                S_SKIP: begin
                    if (dly_q == DLY_W'(SKIP_DLY - 1)) state_q <= S_NEXT;
                    else dly_q <= dly_q + DLY_W'(1);
                end
                S_START: if (slot_end) begin
                    state_q <= S_ADDR_W;
                    shreg_q <= {SLAVE_ADDR, 1'b0};
                    bit_q   <= '0;
                end
                S_RESTART: if (slot_end) begin
                    state_q <= S_ADDR_R;
                    shreg_q <= {SLAVE_ADDR, 1'b1};
                    bit_q   <= '0;
                end
                S_ADDR_W, S_REG, S_DHI, S_DLO, S_ADDR_R: if (slot_end) begin
                    if (bit_q == 3'd7) begin
                        state_q <= S_ACK;
                        ret_q   <= tx_ret;
                    end else begin
                        bit_q   <= bit_q + 3'd1;
                        shreg_q <= {shreg_q[6:0], 1'b0};
                    end
                end
                S_ACK: if (slot_end) begin
                    bit_q <= '0;
                    if (sda_s_q) begin
                        nack_q  <= 1'b1;
                        state_q <= S_STOP;
                    end else begin
                        state_q <= ret_q;
                        case (ret_q)
                            S_REG:   shreg_q <= data_q[23:16];
                            S_DHI:   shreg_q <= data_q[15:8];
                            S_DLO:   shreg_q <= data_q[7:0];
                            default: shreg_q <= shreg_q;
                        endcase
                    end
                end
                S_RDHI, S_RDLO: if (slot_end) begin
                    if (bit_q == 3'd7) begin
                        bit_q   <= '0;
                        state_q <= (state_q == S_RDHI) ? S_MACK : S_MNACK;
                    end else bit_q <= bit_q + 3'd1;
                end
                S_MACK: if (slot_end) state_q <= S_RDLO;
                S_MNACK: if (slot_end) begin
                    state_q    <= S_STOP;
                    rd_data_q  <= rx_q;
                    rd_valid_q <= 1'b1;
                end
                S_STOP: if (slot_end) begin
                    if (!nack_q) state_q <= S_NEXT;
                    else if (retry_q == RTY_W'(MAX_RETRY)) begin
                        err_q   <= 1'b1;
                        retry_q <= '0;
                        state_q <= S_NEXT;
                    end else begin
                        retry_q <= retry_q + RTY_W'(1);
                        state_q <= S_LOAD;
                    end
                end
                S_NEXT: begin
                    retry_q <= '0;
                    if (lut_size == 8'd0 || idx_q == lut_size - 8'd1) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q   <= idx_q + 8'd1;
                        state_q <= S_LOAD;
                    end
                end
                S_DONE:  done_q <= 1'b1;
                default: state_q <= S_INIT;
            endcase
        end
    end

    assign lut_index  = idx_q;
    assign i2c_scl    = scl_q;
    assign i2c_sda_oe = oe_q;
    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign cfg_done   = done_q;
    assign cfg_err    = err_q;
endmodule

// File: tb/tb_i2c_mt9v034_cfg_master.sv
// Directed bench for i2c_mt9v034_cfg_master with a behavioural MT9V034 slave on the open-drain bus.
// The slave logs START/STOP, master-written bytes and master ACK/NACK bits for inspection.
module tb_i2c_mt9v034_cfg_master;
    localparam int EV_S = 256, EV_P = 512, EV_MACK = 768, EV_MNACK = 769;

    logic        clk, rst;
    logic [7:0]  lut_index, lut_size;
    logic [23:0] lut_data;
    logic        i2c_scl, i2c_sda_oe, i2c_sda_i;
    logic [15:0] rd_data;
    logic        rd_valid, cfg_done, cfg_err;

    int n_checks, n_errors;
    int logq[$];

    logic        slv_drv;
    logic [15:0] regs [256];
    logic        p_scl, p_sda, mack;
    int          mphase, nxt, bitc, byte_no;
    logic [7:0]  rxb, ptr, hib;
    logic [15:0] txs;
    logic        nack_en;

    assign i2c_sda_i = !(i2c_sda_oe || slv_drv);
    assign nack_en   = (lut_index == 8'd21);

    function automatic logic [23:0] lut_f(input logic [7:0] i);
        case (i)
            8'd0:    return 24'h0D_0000;
            8'd1:    return 24'h00_0000;
            8'd2:    return 24'h0C_0001;
            8'd5:    return 24'h00_1313;
            default: return {i + 8'h20, 8'hA5, i};
        endcase
    endfunction
    assign lut_data = lut_f(lut_index);

    i2c_mt9v034_cfg_master #(.CLK_DIV(2), .INIT_DLY(10), .SLAVE_ADDR(7'h48), .READ_CNT(2),
                             .SKIP_DLY(8), .MAX_RETRY(3)) dut (
        .clk(clk), .rst(rst), .lut_index(lut_index), .lut_data(lut_data), .lut_size(lut_size),
        .i2c_scl(i2c_scl), .i2c_sda_oe(i2c_sda_oe), .i2c_sda_i(i2c_sda_i), .rd_data(rd_data),
        .rd_valid(rd_valid), .cfg_done(cfg_done), .cfg_err(cfg_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Slave phases: 0 idle, 1 address, 2 register, 3 data hi, 4 data lo, 5 ignore, 6 reading.
    task automatic model_step();
        logic s, d;
        s = i2c_scl;
        d = i2c_sda_i;
        if (rst) begin
            slv_drv = 1'b0; mphase = 0; bitc = 0;
        end else if (p_scl && s && p_sda && !d) begin
            logq.push_back(EV_S); mphase = 1; bitc = 0; rxb = 8'h00;
        end else if (p_scl && s && !p_sda && d) begin
            logq.push_back(EV_P); mphase = 0; slv_drv = 1'b0;
        end else if (!p_scl && s) begin
            if (mphase == 6) begin
                if (bitc < 8) bitc++;
                else if (bitc == 8) begin
                    logq.push_back(d ? EV_MNACK : EV_MACK); mack = d; bitc = 9;
                end
            end else if (mphase != 0 && bitc < 8) begin
                rxb = {rxb[6:0], d}; bitc++;
            end
        end else if (p_scl && !s) begin
            if (mphase == 6) begin
                if (bitc >= 1 && bitc <= 7) begin slv_drv = !txs[15]; txs = txs << 1; end
                else if (bitc == 8) slv_drv = 1'b0;
                else if (bitc == 9) begin
                    if (!mack && byte_no == 0) begin
                        byte_no = 1; bitc = 0; slv_drv = !txs[15]; txs = txs << 1;
                    end else begin
                        slv_drv = 1'b0; mphase = 5; bitc = 0;
                    end
                end
            end else if (mphase >= 1 && mphase <= 5) begin
                if (bitc == 8) begin
                    logq.push_back(int'(rxb));
                    slv_drv = 1'b1;
                    case (mphase)
                        1: begin
                            if (rxb == 8'h90 && !nack_en) nxt = 2;
                            else if (rxb == 8'h91) begin nxt = 6; txs = regs[ptr]; end
                            else begin nxt = 5; slv_drv = 1'b0; end
                        end
                        2: begin ptr = rxb; nxt = 3; end
                        3: begin hib = rxb; nxt = 4; end
                        4: begin regs[ptr] = {hib, rxb}; nxt = 5; end
                        default: begin nxt = 5; slv_drv = 1'b0; end
                    endcase
                    bitc = 9;
                end else if (bitc == 9) begin
                    slv_drv = 1'b0; bitc = 0; mphase = nxt;
                    if (nxt == 6) begin byte_no = 0; slv_drv = !txs[15]; txs = txs << 1; end
                end
            end
        end
        p_scl = s;
        p_sda = d;
    endtask

    initial begin
        slv_drv = 1'b0; p_scl = 1'b1; p_sda = 1'b1; mphase = 0; bitc = 0; nxt = 0;
        byte_no = 0; mack = 1'b1; rxb = '0; ptr = '0; hib = '0; txs = '0;
        for (int i = 0; i < 256; i++) regs[i] = 16'h0000;
        regs[8'h00] = 16'h1313;
        regs[8'h0D] = 16'h0300;
        forever begin
            @(negedge clk);
            model_step();
        end
    end

    task automatic wait_index(input logic [7:0] idx, input int budget);
        int n = 0;
        while (lut_index !== idx && n < budget) begin @(negedge clk); n++; end
        n_checks++;
        if (lut_index !== idx) begin
            n_errors++;
            $display("FAIL wait_index: lut_index=%0d, wanted %0d within %0d cycles", lut_index, idx, budget);
        end
    endtask

    task automatic wait_rd_valid(input int budget);
        int n = 0;
        while (rd_valid !== 1'b1 && n < budget) begin @(negedge clk); n++; end
        n_checks++;
        if (rd_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL wait_rd_valid: no rd_valid pulse within %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        int lows = 0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks += 7;
        if (i2c_scl !== 1'b1)    begin n_errors++; $display("FAIL reset_scl: got %b, want 1", i2c_scl); end
        if (i2c_sda_oe !== 1'b0) begin n_errors++; $display("FAIL reset_oe: got %b, want 0", i2c_sda_oe); end
        if (lut_index !== 8'd0)  begin n_errors++; $display("FAIL reset_index: got %0d, want 0", lut_index); end
        if (cfg_done !== 1'b0)   begin n_errors++; $display("FAIL reset_done: got %b, want 0", cfg_done); end
        if (cfg_err !== 1'b0)    begin n_errors++; $display("FAIL reset_err: got %b, want 0", cfg_err); end
        if (rd_valid !== 1'b0)   begin n_errors++; $display("FAIL reset_rd_valid: got %b, want 0", rd_valid); end
        if (rd_data !== 16'h0)   begin n_errors++; $display("FAIL reset_rd_data: got %h, want 0000", rd_data); end
        rst = 1'b0;
        repeat (10) begin @(negedge clk); if (i2c_scl !== 1'b1) lows++; end
        n_checks++;
        if (lows != 0) begin n_errors++; $display("FAIL init_quiet: SCL low in %0d cycles, want 0", lows); end
    endtask

    task automatic test_read();
        int exp[$];
        wait_rd_valid(3000);
        n_checks += 2;
        if (rd_data !== 16'h0300) begin n_errors++; $display("FAIL read0_data: got %h, want 0300", rd_data); end
        if (lut_index !== 8'd0)   begin n_errors++; $display("FAIL read0_index: got %0d, want 0", lut_index); end
        wait_index(8'd1, 200);
        logq.delete();
        wait_rd_valid(3000);
        n_checks++;
        if (rd_data !== 16'h1313) begin n_errors++; $display("FAIL read1_data: got %h, want 1313", rd_data); end
        @(negedge clk);
        n_checks++;
        if (rd_valid !== 1'b0) begin n_errors++; $display("FAIL read1_pulse: rd_valid still %b, want 0", rd_valid); end
        wait_index(8'd2, 200);
        exp = '{EV_S, 'h90, 'h00, EV_S, 'h91, EV_MACK, EV_MNACK, EV_P};
        n_checks++;
        if (logq.size() != exp.size()) begin
            n_errors++; $display("FAIL read1_log_len: got %0d events, want %0d", logq.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < logq.size(); i++) begin
            n_checks++;
            if (logq[i] !== exp[i]) begin n_errors++; $display("FAIL read1_event%0d: got %h, want %h", i, logq[i], exp[i]); end
        end
    endtask

    task automatic test_write();
        int exp[$];
        wait_index(8'd2, 200);
        logq.delete();
        wait_index(8'd3, 1000);
        exp = '{EV_S, 'h90, 'h0C, 'h00, 'h01, EV_P};
        n_checks++;
        if (logq.size() != exp.size()) begin
            n_errors++; $display("FAIL write2_log_len: got %0d events, want %0d", logq.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < logq.size(); i++) begin
            n_checks++;
            if (logq[i] !== exp[i]) begin n_errors++; $display("FAIL write2_event%0d: got %h, want %h", i, logq[i], exp[i]); end
        end
        n_checks++;
        if (regs[8'h0C] !== 16'h0001) begin n_errors++; $display("FAIL write2_reg: got %h, want 0001", regs[8'h0C]); end
    endtask

    task automatic test_skip();
        int cyc = 0, lows = 0;
        wait_index(8'd5, 2000);
        logq.delete();
        while (lut_index !== 8'd6 && cyc < 100) begin
            @(negedge clk); cyc++;
            if (i2c_scl !== 1'b1) lows++;
        end
        n_checks += 4;
        if (lut_index !== 8'd6) begin n_errors++; $display("FAIL skip_advance: lut_index=%0d, want 6", lut_index); end
        if (cyc < 8)            begin n_errors++; $display("FAIL skip_len: %0d cycles, want >= 8", cyc); end
        if (logq.size() != 0)   begin n_errors++; $display("FAIL skip_bus: %0d bus events, want 0", logq.size()); end
        if (lows != 0)          begin n_errors++; $display("FAIL skip_scl: SCL low %0d cycles, want 0", lows); end
    endtask

    task automatic test_nack();
        int ns = 0, np = 0, na = 0;
        wait_index(8'd21, 20000);
        n_checks++;
        if (cfg_err !== 1'b0) begin n_errors++; $display("FAIL nack_err_before: got %b, want 0", cfg_err); end
        logq.delete();
        wait_index(8'd22, 3000);
        foreach (logq[i]) begin
            if (logq[i] == EV_S) ns++;
            if (logq[i] == EV_P) np++;
            if (logq[i] == 'h90) na++;
        end
        n_checks += 4;
        if (ns != 4) begin n_errors++; $display("FAIL nack_starts: got %0d, want 4", ns); end
        if (np != 4) begin n_errors++; $display("FAIL nack_stops: got %0d, want 4", np); end
        if (na != 4) begin n_errors++; $display("FAIL nack_addr_bytes: got %0d, want 4", na); end
        if (cfg_err !== 1'b1) begin n_errors++; $display("FAIL nack_err_after: got %b, want 1", cfg_err); end
        wait_index(8'd23, 1000);
        n_checks++;
        if (regs[8'h36] !== 16'hA516) begin n_errors++; $display("FAIL next_after_nack_reg: got %h, want a516", regs[8'h36]); end
    endtask

    task automatic test_done();
        int exp[$];
        int n = 0, busy = 0;
        wait_index(8'd23, 1000);
        logq.delete();
        while (cfg_done !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        n_checks += 4;
        if (cfg_done !== 1'b1)        begin n_errors++; $display("FAIL done_flag: got %b, want 1", cfg_done); end
        if (lut_index !== 8'd23)      begin n_errors++; $display("FAIL done_index: got %0d, want 23", lut_index); end
        if (regs[8'h37] !== 16'hA517) begin n_errors++; $display("FAIL done_last_reg: got %h, want a517", regs[8'h37]); end
        if (cfg_err !== 1'b1)         begin n_errors++; $display("FAIL done_err_sticky: got %b, want 1", cfg_err); end
        exp = '{EV_S, 'h90, 'h37, 'hA5, 'h17, EV_P};
        n_checks++;
        if (logq.size() != exp.size()) begin
            n_errors++; $display("FAIL done_log_len: got %0d events, want %0d", logq.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < logq.size(); i++) begin
            n_checks++;
            if (logq[i] !== exp[i]) begin n_errors++; $display("FAIL done_event%0d: got %h, want %h", i, logq[i], exp[i]); end
        end
        repeat (20) begin
            @(negedge clk);
            if (i2c_scl !== 1'b1 || i2c_sda_oe !== 1'b0 || lut_index !== 8'd23) busy++;
        end
        n_checks++;
        if (busy != 0) begin n_errors++; $display("FAIL done_idle: %0d non-idle cycles, want 0", busy); end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks += 3;
        if (cfg_done !== 1'b0)  begin n_errors++; $display("FAIL rst2_done: got %b, want 0", cfg_done); end
        if (cfg_err !== 1'b0)   begin n_errors++; $display("FAIL rst2_err: got %b, want 0", cfg_err); end
        if (lut_index !== 8'd0) begin n_errors++; $display("FAIL rst2_index: got %0d, want 0", lut_index); end
        rst = 1'b0;
        logq.delete();
        while (logq.size() < 2 && n < 400) begin @(negedge clk); n++; end
        n = 0;
        while (!(i2c_scl === 1'b0 && i2c_sda_oe === 1'b1) && n < 200) begin @(negedge clk); n++; end
        n_checks++;
        if (!(i2c_scl === 1'b0 && i2c_sda_oe === 1'b1)) begin
            n_errors++; $display("FAIL mid_busy: scl=%b oe=%b, want scl=0 oe=1 before reset", i2c_scl, i2c_sda_oe);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks += 2;
        if (i2c_scl !== 1'b1)    begin n_errors++; $display("FAIL mid_rst_scl: got %b, want 1", i2c_scl); end
        if (i2c_sda_oe !== 1'b0) begin n_errors++; $display("FAIL mid_rst_oe: got %b, want 0", i2c_sda_oe); end
        @(negedge clk);
        rst = 1'b0;
        logq.delete();
        wait_rd_valid(3000);
        n_checks += 4;
        if (rd_data !== 16'h0300) begin n_errors++; $display("FAIL restart_data: got %h, want 0300", rd_data); end
        if (logq.size() < 3) begin
            n_errors++; $display("FAIL restart_log_len: got %0d events, want >= 3", logq.size());
        end else begin
            if (logq[0] !== EV_S) begin n_errors++; $display("FAIL restart_start: got %h, want %h", logq[0], EV_S); end
            if (logq[2] !== 'h0D) begin n_errors++; $display("FAIL restart_reg: got %h, want 0d", logq[2]); end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        lut_size = 8'd24;
        test_reset();
        test_read();
        test_write();
        test_skip();
        test_nack();
        test_done();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
